// File: rtl/uart_pkg.sv
// Shared UART definitions: autobaud FSM state encoding, RX frame-format encodings
// and the reset divisor (115200 baud at 50 MHz).
package uart_pkg;

  localparam int unsigned UART_DEF_DIV = 434;

  typedef logic [2:0] ab_state_t;

  localparam ab_state_t ST_OFF        = 3'd0;
  localparam ab_state_t ST_WAIT_IDLE  = 3'd1;
  localparam ab_state_t ST_WAIT_START = 3'd2;
  localparam ab_state_t ST_MEASURE    = 3'd3;
  localparam ab_state_t ST_WAIT_STOP  = 3'd4;
  localparam ab_state_t ST_CHECK      = 3'd5;
  localparam ab_state_t ST_LOCKED     = 3'd6;

  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_t;
  typedef enum logic [1:0] {DBITS_5, DBITS_6, DBITS_7, DBITS_8} data_bits_t;

endpackage

// File: rtl/uart_autobaud_ctrl_if.sv
// Register-side and RX-side signals of the autobaud controller, plus its FSM state for debug.
interface uart_autobaud_ctrl_if;
  import uart_pkg::*;

  // ab_start / ab_abort are single-cycle request pulses with no ready: the controller
  // acts on the cycle it samples them. ab_done is a single-cycle completion pulse;
  // ab_error is level and sticky until the next accepted ab_start.
  logic        ab_en;
  logic [15:0] cfg_divisor;
  logic        cfg_rx_en;
  logic        ab_start;
  logic        ab_abort;
  logic        rx;
  logic [15:0] rx_divisor;
  logic        rx_en;
  logic        ab_busy;
  logic        ab_locked;
  logic        ab_done;
  logic        ab_error;
  ab_state_t   ab_state;

  modport master (
    output ab_en, cfg_divisor, cfg_rx_en, ab_start, ab_abort, rx,
    input  rx_divisor, rx_en, ab_busy, ab_locked, ab_done, ab_error, ab_state
  );

  modport slave (
    input  ab_en, cfg_divisor, cfg_rx_en, ab_start, ab_abort, rx,
    output rx_divisor, rx_en, ab_busy, ab_locked, ab_done, ab_error, ab_state
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the raw rx line plus a delay flop for edge detection.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic line,
  output logic fall,
  output logic rise
);

  logic sync_q;
  logic line_q;
  logic line_d;

  // Reset to the idle (high) level so release of reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b1;
      line_q <= 1'b1;
      line_d <= 1'b1;
    end else begin
      sync_q <= rx;
      line_q <= sync_q;
      line_d <= line_q;
    end
  end

  assign line = line_q;
  assign fall = line_d & ~line_q;
  assign rise = ~line_d & line_q;

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// UART RX configuration controller: manual divisor passthrough or 0x55 autobaud lock.
// Optional macro UART_AB_TOL_CHECK_EN adds a +/-12.5% check of each two-bit pair interval.
module uart_autobaud_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned DEF_DIV     = UART_DEF_DIV,
  parameter int unsigned MIN_DIV     = 16,
  parameter int unsigned MAX_DIV     = 65535,
  parameter int unsigned IDLE_CYCLES = 1024
) (
  input logic                  clk,
  input logic                  rst_n,
  uart_autobaud_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] IDLE_N   = CNT_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] MEAS_LIM = CNT_W'(2 * MAX_DIV);
  localparam logic [CNT_W-1:0] MAX_D    = CNT_W'(MAX_DIV);
  localparam logic [15:0]      MIN_D    = 16'(MIN_DIV);

  ab_state_t        state;
  logic [CNT_W-1:0] idle_cnt, interval, total;
  logic [1:0]       edge_cnt;
  logic             line, fall, rise;

  logic [CNT_W-1:0] idle_inc, interval_inc, total_inc, tot8, stop_lim;
  logic [CNT_W:0]   total_rnd;
  logic [15:0]      div_new;
  logic             busy_state, range_bad, tol_bad, fail;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (bus.rx),
    .line  (line),
    .fall  (fall),
    .rise  (rise)
  );

  always_comb begin
    idle_inc     = (idle_cnt == CNT_MAX) ? idle_cnt : idle_cnt + CNT_ONE;
    interval_inc = (interval == CNT_MAX) ? interval : interval + CNT_ONE;
    total_inc    = (total == CNT_MAX) ? total : total + CNT_ONE;
    tot8         = total >> 3;
    stop_lim     = tot8 << 1;
    total_rnd    = {1'b0, total} + (CNT_W+1)'(4);
    div_new      = 16'(total_rnd >> 3);
    range_bad    = (div_new < MIN_D) || (tot8 > MAX_D);
    busy_state   = (state == ST_WAIT_IDLE) || (state == ST_WAIT_START) ||
                   (state == ST_MEASURE) || (state == ST_WAIT_STOP) || (state == ST_CHECK);
    case (state)
      ST_MEASURE:   fail = !fall && (interval > MEAS_LIM);
      ST_WAIT_STOP: fail = !rise && (interval > stop_lim);
      ST_CHECK:     fail = range_bad || tol_bad;
      default:      fail = 1'b0;
    endcase
  end

`ifdef UART_AB_TOL_CHECK_EN
  logic [CNT_W-1:0] p [4];
  logic [CNT_W-1:0] quarter, diff;

  // Each stored interval spans two bit times, i.e. nominally a quarter of total.
  always_comb begin
    quarter = total >> 2;
    diff    = '0;
    tol_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      diff = (p[i] > quarter) ? p[i] - quarter : quarter - p[i];
      if (diff > (total >> 5)) tol_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p <= '{default: '0};
    else if (bus.ab_en && state == ST_MEASURE && fall) p[edge_cnt] <= interval;
  end
`else
  assign tol_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_OFF;
      idle_cnt       <= '0;
      interval       <= '0;
      total          <= '0;
      edge_cnt       <= '0;
      bus.rx_divisor <= 16'(DEF_DIV);
      bus.rx_en      <= 1'b0;
      bus.ab_busy    <= 1'b0;
      bus.ab_locked  <= 1'b0;
      bus.ab_done    <= 1'b0;
      bus.ab_error   <= 1'b0;
    end else begin
      bus.ab_done <= 1'b0;
      if (!bus.ab_en) begin
        state          <= ST_OFF;
        bus.rx_divisor <= bus.cfg_divisor;
        bus.rx_en      <= bus.cfg_rx_en;
        bus.ab_busy    <= 1'b0;
        bus.ab_locked  <= 1'b0;
      end else if (bus.ab_abort) begin
        // Abort beats a simultaneous start; an earlier lock is deliberately not restored.
        if (busy_state) begin
          state         <= ST_OFF;
          bus.ab_busy   <= 1'b0;
          bus.rx_en     <= 1'b0;
          bus.ab_locked <= 1'b0;
        end
      end else if (bus.ab_start) begin
        state         <= ST_WAIT_IDLE;
        idle_cnt      <= '0;
        bus.ab_error  <= 1'b0;
        bus.ab_busy   <= 1'b1;
        bus.rx_en     <= 1'b0;
        bus.ab_locked <= 1'b0;
      end else if (fail) begin
        state         <= ST_OFF;
        bus.ab_error  <= 1'b1;
        bus.ab_busy   <= 1'b0;
        bus.rx_en     <= 1'b0;
        bus.ab_locked <= 1'b0;
      end else begin
        case (state)
          ST_WAIT_IDLE: begin
            if (!line) idle_cnt <= '0;
            else begin
              idle_cnt <= idle_inc;
              if (idle_inc >= IDLE_N) state <= ST_WAIT_START;
            end
          end
          ST_WAIT_START: begin
            if (fall) begin
              state    <= ST_MEASURE;
              edge_cnt <= '0;
              interval <= '0;
              total    <= '0;
            end
          end
          ST_MEASURE: begin
            total <= total_inc;
            if (fall) begin
              interval <= '0;
              edge_cnt <= edge_cnt + 2'd1;
              // Fourth stored fall opens d7: total now covers eight bit times.
              if (edge_cnt == 2'd3) state <= ST_WAIT_STOP;
            end else begin
              interval <= interval_inc;
            end
          end
          ST_WAIT_STOP: begin
            interval <= interval_inc;
            if (rise) state <= ST_CHECK;
          end
          ST_CHECK: begin
            state          <= ST_LOCKED;
            bus.rx_divisor <= div_new;
            bus.rx_en      <= 1'b1;
            bus.ab_locked  <= 1'b1;
            bus.ab_busy    <= 1'b0;
            bus.ab_done    <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.ab_state = state;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Directed bench for uart_autobaud_ctrl: expected output snapshots are queued by the
// driver and compared by a monitor on ab_done, rising ab_error, or a requested snapshot.
module tb_uart_autobaud_ctrl;
  import uart_pkg::*;

  localparam int W = 21;  // {rx_divisor, rx_en, ab_busy, ab_locked, ab_error, ab_done}

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  uart_autobaud_ctrl_if ab_if ();

  // MAX_DIV narrowed so the stuck-low timeout (2*MAX_DIV clocks) stays short; 5208 remains legal.
  uart_autobaud_ctrl #(.MAX_DIV(5400)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ab_if)
  );

  logic [W-1:0] exp_q[$];
  string        exp_name_q[$];
  logic [W-1:0] snap_q[$];
  string        snap_name_q[$];
  int           n_vec = 0;
  int           n_fail = 0;
  logic         snap_req = 1'b0;
  logic         err_prev = 1'b0;

  function automatic logic [W-1:0] mk(input int div, input logic en, input logic busy,
                                      input logic locked, input logic err, input logic done);
    return {16'(div), en, busy, locked, err, done};
  endfunction

  function automatic string fmt(input logic [W-1:0] v);
    return $sformatf("div=%0d en=%b busy=%b locked=%b err=%b done=%b",
                     v[20:5], v[4], v[3], v[2], v[1], v[0]);
  endfunction

  function automatic logic [W-1:0] act_vec();
    return {ab_if.rx_divisor, ab_if.rx_en, ab_if.ab_busy, ab_if.ab_locked,
            ab_if.ab_error, ab_if.ab_done};
  endfunction

  task automatic compare(input logic [W-1:0] exp, input string nm);
    logic [W-1:0] act;
    act = act_vec();
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", nm, fmt(act), fmt(exp));
    end
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (ab_if.ab_done === 1'b1 || (ab_if.ab_error === 1'b1 && err_prev !== 1'b1)) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_event: got %s, expected no event", fmt(act_vec()));
        end else compare(exp_q.pop_front(), exp_name_q.pop_front());
      end
      if (snap_req) begin
        if (snap_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL snapshot_without_expectation: got %s", fmt(act_vec()));
        end else compare(snap_q.pop_front(), snap_name_q.pop_front());
      end
      err_prev = ab_if.ab_error;
    end
  end

  // Driver tasks
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input string nm, input logic [W-1:0] v);
    exp_q.push_back(v);
    exp_name_q.push_back(nm);
  endtask

  task automatic snap(input string nm, input logic [W-1:0] v);
    snap_q.push_back(v);
    snap_name_q.push_back(nm);
    snap_req = 1'b1;
    cycles(1);
    snap_req = 1'b0;
  endtask

  task automatic start_pulse();
    ab_if.ab_start = 1'b1;
    cycles(1);
    ab_if.ab_start = 1'b0;
  endtask

  task automatic idle_line();
    ab_if.rx = 1'b1;
    cycles(1050);
  endtask

  task automatic send_frame(input logic [7:0] data, input int b, input int snap_bit,
                            input int stop_len, input string snap_nm, input logic [W-1:0] snap_v);
    ab_if.rx = 1'b0;
    cycles(b);
    for (int i = 0; i < 8; i++) begin
      ab_if.rx = data[i];
      if (i == snap_bit) begin
        cycles(b - 1);
        snap(snap_nm, snap_v);
      end else cycles(b);
    end
    ab_if.rx = 1'b1;
    cycles(stop_len);
  endtask

  task automatic wait_drain(input int budget, input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s_timeout: got no event after %0d cycles, expected %s",
               nm, budget, fmt(exp_q[0]));
      exp_q.delete();
      exp_name_q.delete();
    end
  endtask

  initial begin
    ab_if.ab_en       = 1'b1;
    ab_if.cfg_divisor = 16'd0;
    ab_if.cfg_rx_en   = 1'b0;
    ab_if.ab_start    = 1'b0;
    ab_if.ab_abort    = 1'b0;
    ab_if.rx          = 1'b1;
    #1 rst_n = 1'b0;
    cycles(3);
    snap("reset_values", mk(434, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    cycles(5);

    // 10 clk/bit measures div 10 < MIN_DIV
    start_pulse();
    idle_line();
    push_ev("min_div_fail", mk(434, 0, 0, 0, 1, 0));
    send_frame(8'h55, 10, -1, 20, "", '0);
    wait_drain(100, "min_div_fail");

    // Manual passthrough, one-cycle latency; error flag stays sticky
    ab_if.ab_en       = 1'b0;
    ab_if.cfg_divisor = 16'd5208;
    ab_if.cfg_rx_en   = 1'b1;
    cycles(1);
    snap("manual_5208", mk(5208, 1, 0, 0, 1, 0));
    ab_if.cfg_divisor = 16'd100;
    ab_if.cfg_rx_en   = 1'b0;
    cycles(1);
    snap("manual_100", mk(100, 0, 0, 0, 1, 0));

    // Lock at 434 clk/bit
    ab_if.ab_en = 1'b1;
    cycles(1);
    start_pulse();
    snap("start_busy", mk(100, 0, 1, 0, 0, 0));
    idle_line();
    push_ev("lock_434", mk(434, 1, 0, 1, 0, 1));
    send_frame(8'h55, 434, -1, 20, "", '0);
    wait_drain(200, "lock_434");
    snap("lock_434_hold", mk(434, 1, 0, 1, 0, 0));

    // Lock at 5208, then relock at 868 with the old divisor held while measuring
    start_pulse();
    idle_line();
    push_ev("lock_5208", mk(5208, 1, 0, 1, 0, 1));
    send_frame(8'h55, 5208, -1, 20, "", '0);
    wait_drain(200, "lock_5208");
    start_pulse();
    idle_line();
    push_ev("relock_868", mk(868, 1, 0, 1, 0, 1));
    send_frame(8'h55, 868, 4, 20, "relock_measuring", mk(5208, 0, 1, 0, 0, 0));
    wait_drain(200, "relock_868");

    // 0x00 with line held low: interval timeout
    start_pulse();
    idle_line();
    push_ev("stuck_low", mk(868, 0, 0, 0, 1, 0));
    ab_if.rx = 1'b0;
    wait_drain(12000, "stuck_low");
    ab_if.rx = 1'b1;
    cycles(50);

    // Abort and start together mid-measurement: abort wins
    start_pulse();
    idle_line();
    ab_if.rx = 1'b0;
    cycles(434);
    ab_if.rx = 1'b1;
    cycles(434);
    ab_if.rx = 1'b0;
    cycles(200);
    ab_if.ab_abort = 1'b1;
    ab_if.ab_start = 1'b1;
    cycles(1);
    ab_if.ab_abort = 1'b0;
    ab_if.ab_start = 1'b0;
    cycles(1);
    snap("abort_start", mk(868, 0, 0, 0, 0, 0));
    cycles(234);
    ab_if.rx = 1'b1;
    cycles(1100);
    snap("abort_stays_off", mk(868, 0, 0, 0, 0, 0));

    // Reset mid-MEASURE
    start_pulse();
    idle_line();
    ab_if.rx = 1'b0;
    cycles(434);
    ab_if.rx = 1'b1;
    cycles(100);
    rst_n = 1'b0;
    cycles(2);
    snap("reset_mid_measure", mk(434, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    cycles(5);

`ifdef UART_AB_TOL_CHECK_EN
    // 0x57 followed by 0x55: uneven pair intervals
    start_pulse();
    idle_line();
    push_ev("tol_0x57", mk(434, 0, 0, 0, 1, 0));
    send_frame(8'h57, 434, -1, 434, "", '0);
    send_frame(8'h55, 434, -1, 20, "", '0);
    wait_drain(200, "tol_0x57");
`endif

    cycles(10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
